// File: rtl/lut_neuron_pkg.sv
// rtl/lut_neuron_pkg.sv - shared types, default sizes and sizing helpers for the programmable LUT neuron
package lut_neuron_pkg;

    localparam int DEF_IN_BITS   = 8;
    localparam int DEF_OUT_BITS  = 1;
    localparam int DEF_BEAT_BITS = 8;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY
    } state_e;

    // Never returns less than 1 so single-entry counters still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    function automatic int beat_count(input int in_bits, input int out_bits, input int beat_bits);
        return table_depth(in_bits) * out_bits / beat_bits;
    endfunction

    localparam int TABLE_DEPTH = table_depth(DEF_IN_BITS);
    localparam int BEATS       = beat_count(DEF_IN_BITS, DEF_OUT_BITS, DEF_BEAT_BITS);

endpackage

// File: rtl/lut_neuron_if.sv
// rtl/lut_neuron_if.sv - config stream, lookup and status bundle; LUT_PROG_READBACK_EN adds readback signals
interface lut_neuron_if #(
    parameter int IN_BITS   = lut_neuron_pkg::DEF_IN_BITS,
    parameter int OUT_BITS  = lut_neuron_pkg::DEF_OUT_BITS,
    parameter int BEAT_BITS = lut_neuron_pkg::DEF_BEAT_BITS
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [BEAT_BITS-1:0] cfg_data;
    logic                 cfg_last;
    logic                 in_valid;
    logic [IN_BITS-1:0]   in_data;
    logic                 out_valid;
    logic [OUT_BITS-1:0]  out_data;
    logic                 loaded;
    logic                 err;
`ifdef LUT_PROG_READBACK_EN
    logic                 rb_start;
    logic                 rb_valid;
    logic [BEAT_BITS-1:0] rb_data;
    logic                 rb_last;
`endif

    modport master (
        output cfg_valid, output cfg_data, output cfg_last,
        output in_valid, output in_data,
`ifdef LUT_PROG_READBACK_EN
        output rb_start, input rb_valid, input rb_data, input rb_last,
`endif
        input cfg_ready, input out_valid, input out_data, input loaded, input err
    );

    modport slave (
        input cfg_valid, input cfg_data, input cfg_last,
        input in_valid, input in_data,
`ifdef LUT_PROG_READBACK_EN
        input rb_start, output rb_valid, output rb_data, output rb_last,
`endif
        output cfg_ready, output out_valid, output out_data, output loaded, output err
    );

endinterface

// File: rtl/lut_neuron_ram.sv
// rtl/lut_neuron_ram.sv - flat truth-table RAM: beat-wide sync write, async entry read (beat read under LUT_PROG_READBACK_EN)
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS   = DEF_IN_BITS,
    parameter int OUT_BITS  = DEF_OUT_BITS,
    parameter int BEAT_BITS = DEF_BEAT_BITS,
    localparam int TBITS    = table_depth(IN_BITS) * OUT_BITS,
    localparam int CNT_W    = clog2(TBITS / BEAT_BITS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [CNT_W-1:0]     waddr,
    input  logic [BEAT_BITS-1:0] wdata,
    input  logic [IN_BITS-1:0]   raddr,
    output logic [OUT_BITS-1:0]  rdata
`ifdef LUT_PROG_READBACK_EN
    ,
    input  logic [CNT_W-1:0]     rb_addr,
    output logic [BEAT_BITS-1:0] rb_rdata
`endif
);
    localparam int AW = clog2(TBITS);

    logic [TBITS-1:0] mem_q;
    logic [AW-1:0]    wbase;
    logic [AW-1:0]    rbase;

    // Bit offsets into the flat table; entries may straddle beat boundaries.
    assign wbase = AW'(waddr) * AW'(BEAT_BITS);
    assign rbase = AW'(raddr) * AW'(OUT_BITS);

    always_ff @(posedge clk) begin
        if (we) mem_q[wbase +: BEAT_BITS] <= wdata;
    end

    assign rdata = mem_q[rbase +: OUT_BITS];

`ifdef LUT_PROG_READBACK_EN
    logic [AW-1:0] rb_base;
    assign rb_base  = AW'(rb_addr) * AW'(BEAT_BITS);
    assign rb_rdata = mem_q[rb_base +: BEAT_BITS];
`endif

endmodule

// File: rtl/lut_neuron_prog.sv
// rtl/lut_neuron_prog.sv - runtime-programmable LUT neuron: load FSM, framing check, registered lookup; LUT_PROG_READBACK_EN adds table readback
module lut_neuron_prog
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS   = DEF_IN_BITS,
    parameter int OUT_BITS  = DEF_OUT_BITS,
    parameter int BEAT_BITS = DEF_BEAT_BITS
) (
    input  logic        clk,
    input  logic        rst,
    lut_neuron_if.slave bus
);
    localparam int NBEATS = beat_count(IN_BITS, OUT_BITS, BEAT_BITS);
    localparam int CNT_W  = clog2(NBEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                loaded_q, loaded_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q, out_data_d;
    logic [OUT_BITS-1:0] ram_rdata;
    logic [CNT_W-1:0]    ram_waddr;
    logic                ram_we;
    logic                cfg_ready;
    logic                cfg_fire;
    logic                lookup;
`ifdef LUT_PROG_READBACK_EN
    logic                 rb_active_q, rb_active_d;
    logic [CNT_W-1:0]     rb_cnt_q, rb_cnt_d;
    logic [BEAT_BITS-1:0] rb_rdata;
`endif

    lut_neuron_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .BEAT_BITS(BEAT_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (bus.cfg_data),
        .raddr   (bus.in_data),
        .rdata   (ram_rdata)
`ifdef LUT_PROG_READBACK_EN
        ,
        .rb_addr (rb_cnt_q),
        .rb_rdata(rb_rdata)
`endif
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        loaded_d  = loaded_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
`ifdef LUT_PROG_READBACK_EN
        cfg_ready = !rb_active_q;
`else
        cfg_ready = 1'b1;
`endif
        cfg_fire  = bus.cfg_valid && cfg_ready;

        // The read is asynchronous and the write lands at the edge, so a lookup
        // in the cycle a reload starts still sees the old table.
        lookup      = bus.in_valid && (state_q == S_READY);
        out_valid_d = lookup;
        out_data_d  = lookup ? ram_rdata : out_data_q;

        case (state_q)
            S_EMPTY, S_READY: begin
                if (cfg_fire) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    loaded_d  = 1'b0;
                    if (bus.cfg_last) begin
                        err_d   = 1'b1;
                        state_d = S_EMPTY;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_LOAD;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_LOAD: begin
                if (cfg_fire) begin
                    ram_we = 1'b1;
                    if (bus.cfg_last && (cnt_q == LAST_BEAT)) begin
                        state_d  = S_READY;
                        loaded_d = 1'b1;
                        cnt_d    = '0;
                    end else if (bus.cfg_last || (cnt_q == LAST_BEAT)) begin
                        err_d   = 1'b1;
                        state_d = S_EMPTY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_EMPTY;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef LUT_PROG_READBACK_EN
    always_comb begin
        rb_active_d = rb_active_q;
        rb_cnt_d    = rb_cnt_q;
        if (rb_active_q) begin
            if (rb_cnt_q == LAST_BEAT) begin
                rb_active_d = 1'b0;
                rb_cnt_d    = '0;
            end else begin
                rb_cnt_d = rb_cnt_q + CNT_W'(1);
            end
        end else if (bus.rb_start && (state_q == S_READY) && !cfg_fire) begin
            rb_active_d = 1'b1;
            rb_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_active_q <= 1'b0;
            rb_cnt_q    <= '0;
        end else begin
            rb_active_q <= rb_active_d;
            rb_cnt_q    <= rb_cnt_d;
        end
    end

    assign bus.rb_valid = rb_active_q;
    assign bus.rb_data  = rb_rdata;
    assign bus.rb_last  = rb_active_q && (rb_cnt_q == LAST_BEAT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            cnt_q       <= '0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.loaded    = loaded_q;
    assign bus.err       = err_q;

endmodule
